// File: rtl/alu_multicycle_if.sv
// Execute-stage ALU request/response bundle.
// Master issues ALUstart with operands; slave answers with ALUvalid/ALUresult.
interface alu_multicycle_if #(
  parameter int WIDTH = 32
);
  logic             ALUstart;
  logic [WIDTH-1:0] ALUoperand1;
  logic [WIDTH-1:0] ALUoperand2;
  logic [2:0]       ALUfunc3;
  logic             ALUsubsra;
  logic             ALUmext;
  logic             ALUready;
  logic             ALUbusy;
  logic             ALUvalid;
  logic [WIDTH-1:0] ALUresult;

  modport master (
    output ALUstart, ALUoperand1, ALUoperand2,
    output ALUfunc3, ALUsubsra, ALUmext,
    input  ALUready, ALUbusy, ALUvalid, ALUresult
  );

  modport slave (
    input  ALUstart, ALUoperand1, ALUoperand2,
    input  ALUfunc3, ALUsubsra, ALUmext,
    output ALUready, ALUbusy, ALUvalid, ALUresult
  );
endinterface

// File: rtl/alu_multicycle.sv
// RV32I/RV32M ALU: single-cycle base ops, iterative mul/div.
// Start/valid handshake; ready only while idle.
module alu_multicycle #(
  parameter int WIDTH = 32
) (
  input logic            clk,
  input logic            rst_n,
  alu_multicycle_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MINV =
    {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE, MUL, DIV, DONE
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0]   a, b;
  logic [2:0]         f3;
  logic [SHW-1:0]     shamt;
  logic               accept;
  logic [WIDTH-1:0]   base_res;

  assign a      = bus.ALUoperand1;
  assign b      = bus.ALUoperand2;
  assign f3     = bus.ALUfunc3;
  assign shamt  = b[SHW-1:0];
  assign accept = bus.ALUstart && (state == IDLE);

  always_comb begin
    base_res = '0;
    unique case (f3)
      3'b000: base_res = bus.ALUsubsra ? a - b : a + b;
      3'b001: base_res = a << shamt;
      3'b010: base_res =
        {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      3'b011: base_res = {{(WIDTH-1){1'b0}}, a < b};
      3'b100: base_res = a ^ b;
      3'b101: base_res = bus.ALUsubsra ?
        WIDTH'($signed(a) >>> shamt) : a >> shamt;
      3'b110: base_res = a | b;
      3'b111: base_res = a & b;
    endcase
  end

  // Division corner cases bypass the iterative loop.
  logic             bzero, ovf, fast;
  logic [WIDTH-1:0] fast_res;

  assign bzero = (b == '0);
  assign ovf   = !f3[0] && (a == MINV) && (b == '1);
  assign fast  = bus.ALUmext && f3[2] && (bzero || ovf);

  always_comb begin
    if (bzero) fast_res = f3[1] ? a : '1;
    else       fast_res = f3[1] ? '0 : MINV;
  end

  // Which operands are treated as signed for this op.
  logic             sa, sb, na, nb;
  logic [WIDTH-1:0] ma, mb;

  assign sa = f3[2] ? !f3[0] : (f3[0] ^ f3[1]);
  assign sb = f3[2] ? !f3[0] : (f3[1:0] == 2'b01);
  assign na = sa && a[WIDTH-1];
  assign nb = sb && b[WIDTH-1];
  assign ma = na ? -a : a;
  assign mb = nb ? -b : b;

  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mc;
  logic [1:0]         op_lo;
  logic               op_na, op_nb;
  logic [SHW-1:0]     cnt;
  logic [WIDTH-1:0]   res;
  logic               last;

  assign last = (cnt == SHW'(WIDTH - 1));

  // Mul step: add multiplicand into the high half, shift right.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_nxt;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   mul_res;

  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} +
                   (acc[0] ? {1'b0, mc} : '0);
  assign mul_nxt = {mul_sum, acc[WIDTH-1:1]};
  assign prod    = (op_na ^ op_nb) ? -mul_nxt : mul_nxt;
  assign mul_res = (op_lo == 2'b00) ?
    prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];

  // Div step: high half is the partial remainder,
  // low half shifts dividend out and quotient in.
  logic [WIDTH:0]     div_r;
  logic               div_ge;
  logic [WIDTH-1:0]   div_d, div_rem;
  logic [2*WIDTH-1:0] div_nxt;
  logic [WIDTH-1:0]   q, r, div_res;

  assign div_r   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_ge  = div_r >= {1'b0, mc};
  assign div_d   = div_r[WIDTH-1:0] - mc;
  assign div_rem = div_ge ? div_d : div_r[WIDTH-1:0];
  assign div_nxt = {div_rem, acc[WIDTH-2:0], div_ge};
  assign q       = div_nxt[WIDTH-1:0];
  assign r       = div_nxt[2*WIDTH-1:WIDTH];
  assign div_res = op_lo[1] ?
    (op_na ? -r : r) :
    ((op_na ^ op_nb) ? -q : q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    bus.ALUready = 1'b0;
    bus.ALUbusy  = 1'b0;
    bus.ALUvalid = 1'b0;
    unique case (state)
      IDLE: begin
        bus.ALUready = 1'b1;
        if (accept) begin
          unique case (1'b1)
            !bus.ALUmext || fast:
              state_nxt = DONE;
            bus.ALUmext && !fast && !f3[2]:
              state_nxt = MUL;
            bus.ALUmext && !fast && f3[2]:
              state_nxt = DIV;
          endcase
        end
      end
      MUL, DIV: begin
        bus.ALUbusy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        bus.ALUvalid = 1'b1;
        state_nxt    = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      mc    <= '0;
      op_lo <= '0;
      op_na <= 1'b0;
      op_nb <= 1'b0;
      cnt   <= '0;
      res   <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          cnt   <= '0;
          op_lo <= f3[1:0];
          op_na <= na;
          op_nb <= nb;
          mc    <= f3[2] ? mb : ma;
          acc   <= {{WIDTH{1'b0}}, f3[2] ? ma : mb};
          if (!bus.ALUmext) res <= base_res;
          else if (fast)    res <= fast_res;
        end
        MUL: begin
          acc <= mul_nxt;
          cnt <= cnt + 1'b1;
          if (last) res <= mul_res;
        end
        DIV: begin
          acc <= div_nxt;
          cnt <= cnt + 1'b1;
          if (last) res <= div_res;
        end
        default: ;
      endcase
    end
  end

  assign bus.ALUresult = res;
endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle.
// Hand-computed vectors, latency and handshake checks.
module tb_alu_multicycle;
  logic clk = 1'b0;
  logic rst_n;
  int   vecs = 0;
  int   errs = 0;

  always #5 clk = ~clk;

  alu_multicycle_if #(.WIDTH(32)) bus ();

  alu_multicycle #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Issue one op; return result, accept-to-valid
  // latency and busy cycles. poke>0 pulses a bogus
  // start with new operands at that cycle.
  task automatic run(input  logic [31:0] a,
                     input  logic [31:0] b,
                     input  logic [2:0]  f3,
                     input  logic        sub,
                     input  logic        mext,
                     input  int          poke,
                     output logic [31:0] res,
                     output int          lat,
                     output int          busy);
    int w;
    @(negedge clk);
    bus.ALUoperand1 = a;
    bus.ALUoperand2 = b;
    bus.ALUfunc3    = f3;
    bus.ALUsubsra   = sub;
    bus.ALUmext     = mext;
    bus.ALUstart    = 1'b1;
    w = 0;
    while (!bus.ALUready && w < 50) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk);
    #1;
    bus.ALUstart = 1'b0;
    lat  = 1;
    busy = 0;
    res  = 'x;
    while (!bus.ALUvalid && lat < 40) begin
      if (bus.ALUbusy) busy++;
      if (poke != 0 && lat == poke) begin
        bus.ALUoperand1 = 32'h1234_5678;
        bus.ALUoperand2 = 32'h0000_0009;
        bus.ALUfunc3    = 3'b000;
        bus.ALUmext     = 1'b0;
        bus.ALUstart    = 1'b1;
      end else begin
        bus.ALUstart = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    bus.ALUstart = 1'b0;
    if (bus.ALUvalid) res = bus.ALUresult;
  endtask

  logic [31:0] res;
  int          lat, busy, nv;

  initial begin
    rst_n           = 1'b0;
    bus.ALUstart    = 1'b0;
    bus.ALUoperand1 = '0;
    bus.ALUoperand2 = '0;
    bus.ALUfunc3    = '0;
    bus.ALUsubsra   = 1'b0;
    bus.ALUmext     = 1'b0;
    #2;
    chk("rst ready", 32'(bus.ALUready), 32'd1);
    chk("rst busy",  32'(bus.ALUbusy),  32'd0);
    chk("rst valid", 32'(bus.ALUvalid), 32'd0);
    chk("rst result", bus.ALUresult, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run(5, 3, 3'b000, 0, 0, 0, res, lat, busy);
    chk("add", res, 32'd8);
    chk("add lat", 32'(lat), 32'd1);
    run(3, 5, 3'b000, 1, 0, 0, res, lat, busy);
    chk("sub", res, 32'hFFFF_FFFE);
    chk("sub lat", 32'(lat), 32'd1);

    run(32'h8000_0000, 32'h24, 3'b101, 1, 0, 0,
        res, lat, busy);
    chk("sra", res, 32'hF800_0000);
    run(32'h8000_0000, 32'h24, 3'b101, 0, 0, 0,
        res, lat, busy);
    chk("srl", res, 32'h0800_0000);
    run(1, 32'h21, 3'b001, 0, 0, 0, res, lat, busy);
    chk("sll", res, 32'd2);

    run(32'hFFFF_FFFF, 1, 3'b010, 0, 0, 0,
        res, lat, busy);
    chk("slt", res, 32'd1);
    run(32'hFFFF_FFFF, 1, 3'b011, 0, 0, 0,
        res, lat, busy);
    chk("sltu", res, 32'd0);

    run(32'h0F0F_00FF, 32'h00FF_0F0F, 3'b100, 0, 0, 0,
        res, lat, busy);
    chk("xor", res, 32'h0FF0_0FF0);
    run(32'h0F0F_00FF, 32'h00FF_0F0F, 3'b110, 0, 0, 0,
        res, lat, busy);
    chk("or", res, 32'h0FFF_0FFF);
    run(32'h0F0F_00FF, 32'h00FF_0F0F, 3'b111, 0, 0, 0,
        res, lat, busy);
    chk("and", res, 32'h000F_000F);

    run(32'hFFFF_FFFF, 2, 3'b000, 0, 1, 0,
        res, lat, busy);
    chk("mul", res, 32'hFFFF_FFFE);
    chk("mul lat", 32'(lat), 32'd33);
    chk("mul busy", 32'(busy), 32'd32);
    run(32'hFFFF_FFFF, 2, 3'b011, 0, 1, 0,
        res, lat, busy);
    chk("mulhu", res, 32'd1);
    run(32'hFFFF_FFFF, 2, 3'b001, 0, 1, 0,
        res, lat, busy);
    chk("mulh", res, 32'hFFFF_FFFF);
    run(32'hFFFF_FFFF, 2, 3'b010, 0, 1, 0,
        res, lat, busy);
    chk("mulhsu", res, 32'hFFFF_FFFF);
    run(32'h8000_0000, 32'h8000_0000, 3'b001, 0, 1, 0,
        res, lat, busy);
    chk("mulh min", res, 32'h4000_0000);

    run(32'hFFFF_FFF9, 2, 3'b100, 0, 1, 0,
        res, lat, busy);
    chk("div", res, 32'hFFFF_FFFD);
    chk("div lat", 32'(lat), 32'd33);
    run(32'hFFFF_FFF9, 2, 3'b110, 0, 1, 0,
        res, lat, busy);
    chk("rem", res, 32'hFFFF_FFFF);
    run(7, 32'hFFFF_FFFE, 3'b110, 0, 1, 0,
        res, lat, busy);
    chk("rem negb", res, 32'd1);
    run(100, 7, 3'b101, 0, 1, 0, res, lat, busy);
    chk("divu", res, 32'd14);
    run(100, 7, 3'b111, 0, 1, 0, res, lat, busy);
    chk("remu", res, 32'd2);

    run(7, 0, 3'b101, 0, 1, 0, res, lat, busy);
    chk("divu0", res, 32'hFFFF_FFFF);
    chk("divu0 lat", 32'(lat), 32'd1);
    run(7, 0, 3'b111, 0, 1, 0, res, lat, busy);
    chk("remu0", res, 32'd7);
    run(32'h8000_0000, 32'hFFFF_FFFF, 3'b100, 0, 1, 0,
        res, lat, busy);
    chk("div ovf", res, 32'h8000_0000);
    chk("div ovf lat", 32'(lat), 32'd1);
    run(32'h8000_0000, 32'hFFFF_FFFF, 3'b110, 0, 1, 0,
        res, lat, busy);
    chk("rem ovf", res, 32'd0);

    run(3, 5, 3'b000, 0, 1, 5, res, lat, busy);
    chk("mul poked", res, 32'd15);
    chk("mul poked lat", 32'(lat), 32'd33);
    nv = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.ALUvalid) nv++;
    end
    chk("no extra valid", 32'(nv), 32'd0);

    @(negedge clk);
    bus.ALUoperand1 = 100;
    bus.ALUoperand2 = 7;
    bus.ALUfunc3    = 3'b100;
    bus.ALUsubsra   = 1'b0;
    bus.ALUmext     = 1'b1;
    bus.ALUstart    = 1'b1;
    @(posedge clk);
    #1;
    bus.ALUstart = 1'b0;
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    chk("div mid busy", 32'(bus.ALUbusy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst ready", 32'(bus.ALUready), 32'd1);
    chk("midrst busy", 32'(bus.ALUbusy), 32'd0);
    chk("midrst result", bus.ALUresult, 32'd0);
    nv = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (bus.ALUvalid) nv++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.ALUvalid) nv++;
    end
    chk("midrst no valid", 32'(nv), 32'd0);
    run(1, 1, 3'b000, 0, 0, 0, res, lat, busy);
    chk("post rst add", res, 32'd2);
    chk("post rst lat", 32'(lat), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end
endmodule
